// File: rtl/mem_io_responder.sv
// Bus target: 256x16 data RAM plus an I/O page (OUTP, INP, CNT, STAT).
// Define MEM_WPROT_EN to write-protect RAM words below WP_LIMIT.
module mem_io_responder #(
   parameter int          DATA_W   = 16,
   parameter int          RAM_AW   = 8,
   parameter logic [15:0] IO_BASE  = 16'hFF00,
   parameter int          WP_LIMIT = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [15:0]       address,
   input  logic [DATA_W-1:0] D_out,
   input  logic              mw_en,
   output logic [DATA_W-1:0] D_in,
   input  logic [DATA_W-1:0] in_port,
   output logic [DATA_W-1:0] out_port,
   output logic              bus_err
);

   localparam int DEPTH = 2**RAM_AW;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] cnt;
   logic [DATA_W-1:0] sync1;
   logic [DATA_W-1:0] sync2;
   logic              unm_err;
   logic              wp_err;

   logic [RAM_AW-1:0] ram_idx;
   logic sel_ram, sel_outp, sel_inp, sel_cnt, sel_stat, sel_unm;
   logic wr, wp_hit, ram_we;

   assign ram_idx  = address[RAM_AW-1:0];
   assign sel_ram  = (address[15:RAM_AW] == '0);
   assign sel_outp = (address == IO_BASE);
   assign sel_inp  = (address == IO_BASE + 16'd1);
   assign sel_cnt  = (address == IO_BASE + 16'd2);
   assign sel_stat = (address == IO_BASE + 16'd3);
   assign sel_unm  = ~(sel_ram | sel_outp | sel_inp
                       | sel_cnt | sel_stat);

   // reset suppresses every write, including RAM
   assign wr = mw_en & ~reset;

`ifdef MEM_WPROT_EN
   assign wp_hit = sel_ram && (int'(ram_idx) < WP_LIMIT);
`else
   assign wp_hit = 1'b0;
`endif

   assign ram_we = wr & sel_ram & ~wp_hit;

   always_ff @(posedge clk) begin
      if (ram_we)
         mem[ram_idx] <= D_out;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_port <= '0;
         cnt      <= '0;
         sync1    <= '0;
         sync2    <= '0;
         unm_err  <= 1'b0;
      end else begin
         sync1 <= in_port;
         sync2 <= sync1;
         if (wr & sel_cnt)
            cnt <= D_out;
         else
            cnt <= cnt + 1'b1;
         if (wr & sel_outp)
            out_port <= D_out;
         if (wr & sel_stat & D_out[0])
            unm_err <= 1'b0;
         else if (wr & sel_unm)
            unm_err <= 1'b1;
      end
   end

`ifdef MEM_WPROT_EN
   always_ff @(posedge clk) begin
      if (reset)
         wp_err <= 1'b0;
      else if (wr & sel_stat & D_out[1])
         wp_err <= 1'b0;
      else if (wr & sel_ram & wp_hit)
         wp_err <= 1'b1;
   end
`else
   assign wp_err = 1'b0;
`endif

   assign bus_err = unm_err | wp_err;

   always_comb begin
      D_in = '0;
      unique case (1'b1)
         sel_ram:  D_in = mem[ram_idx];
         sel_outp: D_in = out_port;
         sel_inp:  D_in = sync2;
         sel_cnt:  D_in = cnt;
         sel_stat: D_in = {{(DATA_W-2){1'b0}}, wp_err, unm_err};
         default:  D_in = '0;
      endcase
   end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder; honours MEM_WPROT_EN when defined.
module tb_mem_io_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] address;
   logic [15:0] D_out;
   logic        mw_en;
   logic [15:0] D_in;
   logic [15:0] in_port;
   logic [15:0] out_port;
   logic        bus_err;

   int n_chk = 0;
   int n_bad = 0;

   mem_io_responder dut (
      .clk      (clk),
      .reset    (reset),
      .address  (address),
      .D_out    (D_out),
      .mw_en    (mw_en),
      .D_in     (D_in),
      .in_port  (in_port),
      .out_port (out_port),
      .bus_err  (bus_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [15:0] got,
                        input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      address = a;
      D_out   = d;
      mw_en   = 1'b1;
      tick();
      mw_en   = 1'b0;
      #1;
   endtask

   task automatic rd(input string tag, input logic [15:0] a,
                     input logic [15:0] exp);
      address = a;
      #1;
      check(tag, D_in, exp);
   endtask

   initial begin
      reset   = 1'b1;
      address = 16'h0000;
      D_out   = 16'h0000;
      mw_en   = 1'b0;
      in_port = 16'h0000;
      tick();
      tick();
      reset   = 1'b0;

      rd("cnt_first", 16'hFF02, 16'h0000);
      tick();
      rd("cnt_second", 16'hFF02, 16'h0001);
      rd("outp_rst", 16'hFF00, 16'h0000);
      rd("stat_rst", 16'hFF03, 16'h0000);
      check("out_port_rst", out_port, 16'h0000);
      check("bus_err_rst", {15'b0, bus_err}, 16'h0000);

      // same-cycle read returns the old word
      wr(16'h0020, 16'h1111);
      address = 16'h0020;
      D_out   = 16'hBEEF;
      mw_en   = 1'b1;
      #1;
      check("ram_old", D_in, 16'h1111);
      tick();
      mw_en   = 1'b0;
      rd("ram_new", 16'h0020, 16'hBEEF);

`ifndef MEM_WPROT_EN
      wr(16'h0000, 16'h0ABC);
`endif
      wr(16'h00FF, 16'h1234);
      rd("ram_top", 16'h00FF, 16'h1234);
`ifndef MEM_WPROT_EN
      rd("ram_noalias", 16'h0000, 16'h0ABC);
`else
      address = 16'h0000;
      #1;
      check("ram_noalias", {15'b0, D_in === 16'h1234}, 16'h0000);
`endif

      wr(16'hFF02, 16'hFFFE);
      rd("cnt_load", 16'hFF02, 16'hFFFE);
      tick();
      rd("cnt_ffff", 16'hFF02, 16'hFFFF);
      tick();
      rd("cnt_wrap", 16'hFF02, 16'h0000);

      wr(16'hFF00, 16'hA5A5);
      check("out_port", out_port, 16'hA5A5);
      rd("outp_rd", 16'hFF00, 16'hA5A5);

      in_port = 16'h00C3;
      tick();
      rd("inp_1edge", 16'hFF01, 16'h0000);
      tick();
      rd("inp_2edge", 16'hFF01, 16'h00C3);
      wr(16'hFF01, 16'h7777);
      rd("inp_ro", 16'hFF01, 16'h00C3);
      check("inp_wr_noerr", {15'b0, bus_err}, 16'h0000);

      wr(16'h0100, 16'h7777);
      check("unm_err", {15'b0, bus_err}, 16'h0001);
      rd("stat_unm", 16'hFF03, 16'h0001);
`ifndef MEM_WPROT_EN
      rd("ram0_keep", 16'h0000, 16'h0ABC);
`endif
      wr(16'hFF03, 16'h0002);
      check("stat_w0_keep", {15'b0, bus_err}, 16'h0001);
      wr(16'hFF03, 16'h0001);
      check("unm_clr", {15'b0, bus_err}, 16'h0000);
      rd("unm_rd", 16'hFEFF, 16'h0000);

      wr(16'h0030, 16'h2222);
      reset   = 1'b1;
      address = 16'h0030;
      D_out   = 16'h9999;
      mw_en   = 1'b1;
      tick();
      reset   = 1'b0;
      mw_en   = 1'b0;
      rd("rst_wr_blk", 16'h0030, 16'h2222);
      check("rst_outp", out_port, 16'h0000);

`ifdef MEM_WPROT_EN
      wr(16'h0005, 16'h5555);
      address = 16'h0005;
      #1;
      check("wp_keep", {15'b0, D_in === 16'h5555}, 16'h0000);
      rd("wp_stat", 16'hFF03, 16'h0002);
      check("wp_err", {15'b0, bus_err}, 16'h0001);
      wr(16'h0010, 16'h6666);
      rd("wp_limit", 16'h0010, 16'h6666);
      wr(16'hFF03, 16'h0002);
      check("wp_clr", {15'b0, bus_err}, 16'h0000);
`else
      wr(16'h0005, 16'h5555);
      rd("nowp_store", 16'h0005, 16'h5555);
      check("nowp_err", {15'b0, bus_err}, 16'h0000);
      rd("nowp_stat", 16'hFF03, 16'h0000);
`endif

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
